// File: rtl/audio_synth.sv
// audio_synth -- multi-channel square-wave tone generator.
//
// Each of NCH channels is loaded with a (half-period, duration) command.
// While its duration is nonzero a channel toggles its square wave every
// 'per' clock cycles (per = 0 is a rest: silent, but the duration still
// counts down). The duration is counted in prescaler ticks of TICK_DIV clocks.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready. cmd_ready is combinational and stays high unless
// the addressed channel is busy and cmd_force is low. Commands to channel
// indices >= NCH are accepted and discarded.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle
//   cmd_ch     target channel index
//   cmd_force  overwrite a busy channel
//   cmd_per    half-period in clk cycles (0 = rest)
//   cmd_dur    duration in ticks (0 = stop channel)
//   ch_busy    per-channel: remaining duration is nonzero
//   ch_done    per-channel one-cycle pulse when the duration expires
//   audio_out  registered mixed 1-bit audio
//
// Build option: define AUDIO_SYNTH_PWM_MIX_EN to replace the OR mix with an
// NCH-level PWM mix (rotating counter compared against the active count).
module audio_synth #(
  parameter int NCH      = 4,
  parameter int PSIZE    = 24,
  parameter int DSIZE    = 8,
  parameter int TICK_DIV = 31250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_ch,
  input  logic             cmd_force,
  input  logic [PSIZE-1:0] cmd_per,
  input  logic [DSIZE-1:0] cmd_dur,
  output logic [NCH-1:0]   ch_busy,
  output logic [NCH-1:0]   ch_done,
  output logic             audio_out
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;

  logic [PSIZE-1:0] per_q     [NCH];
  logic [PSIZE-1:0] per_d     [NCH];
  logic [PSIZE-1:0] per_cnt_q [NCH];
  logic [PSIZE-1:0] per_cnt_d [NCH];
  logic [DSIZE-1:0] dur_q     [NCH];
  logic [DSIZE-1:0] dur_d     [NCH];
  logic [NCH-1:0]   wave_q, wave_d;
  logic [NCH-1:0]   done_q, done_d;
  logic             audio_q, audio_d;

  logic             sel_busy;
  logic             ch_oor;
  logic             accept;
  logic [NCH-1:0]   active;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < NCH; i++) ch_busy[i] = (dur_q[i] != '0);
  end

  // Busy flag of the addressed channel; out-of-range indices read as idle.
  always_comb begin
    sel_busy = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (cmd_ch == 3'(i)) sel_busy = ch_busy[i];
  end

  assign ch_oor    = (32'(cmd_ch) >= 32'(NCH));
  assign cmd_ready = ~sel_busy | cmd_force | ch_oor;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    wave_d = wave_q;
    done_d = '0;
    for (int i = 0; i < NCH; i++) begin
      per_d[i]     = per_q[i];
      per_cnt_d[i] = per_cnt_q[i];
      dur_d[i]     = dur_q[i];
      if (accept && (cmd_ch == 3'(i))) begin
        // A load always wins over a coincident tick and restarts the wave.
        per_d[i]     = cmd_per;
        dur_d[i]     = cmd_dur;
        per_cnt_d[i] = '0;
        wave_d[i]    = 1'b0;
      end else if (dur_q[i] != '0) begin
        if (tick && (dur_q[i] == DSIZE'(1))) begin
          dur_d[i]     = '0;
          per_cnt_d[i] = '0;
          wave_d[i]    = 1'b0;
          done_d[i]    = 1'b1;
        end else begin
          if (tick) dur_d[i] = dur_q[i] - 1'b1;
          if (per_q[i] != '0) begin
            if (per_cnt_q[i] >= per_q[i] - 1'b1) begin
              per_cnt_d[i] = '0;
              wave_d[i]    = ~wave_q[i];
            end else begin
              per_cnt_d[i] = per_cnt_q[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  assign active = wave_q & ch_busy;

`ifdef AUDIO_SYNTH_PWM_MIX_EN
  localparam int MW = (NCH > 1) ? $clog2(NCH) : 1;
  logic [MW-1:0] mix_q, mix_d;
  logic [3:0]    pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) pop = pop + 4'(active[i]);
  end

  assign mix_d   = (mix_q == MW'(NCH - 1)) ? '0 : mix_q + 1'b1;
  assign audio_d = (4'(mix_q) < pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mix_q <= '0;
    else       mix_q <= mix_d;
  end
`else
  assign audio_d = |active;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      wave_q     <= '0;
      done_q     <= '0;
      audio_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        per_q[i]     <= '0;
        per_cnt_q[i] <= '0;
        dur_q[i]     <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      wave_q     <= wave_d;
      done_q     <= done_d;
      audio_q    <= audio_d;
      for (int i = 0; i < NCH; i++) begin
        per_q[i]     <= per_d[i];
        per_cnt_q[i] <= per_cnt_d[i];
        dur_q[i]     <= dur_d[i];
      end
    end
  end

  assign ch_done   = done_q;
  assign audio_out = audio_q;

endmodule

// File: tb/tb_audio_synth.sv
// Testbench for audio_synth (NCH=4, PSIZE=8, DSIZE=4, TICK_DIV=4).
// The reference model tracks each channel as (half-period, ticks remaining,
// cycles since load); the wave level is derived arithmetically from the
// elapsed cycle count.
module tb_audio_synth;

  localparam int NCH      = 4;
  localparam int PSIZE    = 8;
  localparam int DSIZE    = 4;
  localparam int TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_ch = '0;
  logic             cmd_force = 1'b0;
  logic [PSIZE-1:0] cmd_per = '0;
  logic [DSIZE-1:0] cmd_dur = '0;
  logic [NCH-1:0]   ch_busy;
  logic [NCH-1:0]   ch_done;
  logic             audio_out;

  int errors = 0;
  int checks = 0;

  audio_synth #(.NCH(NCH), .PSIZE(PSIZE), .DSIZE(DSIZE), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_force(cmd_force), .cmd_per(cmd_per), .cmd_dur(cmd_dur),
    .ch_busy(ch_busy), .ch_done(ch_done), .audio_out(audio_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int       m_per [NCH];
  int       m_rem [NCH];
  int       m_el  [NCH];
  logic [NCH-1:0] m_done;
  logic     m_audio;
  int       m_tcnt;
  int       m_mix;

  function automatic logic m_wave(input int i);
    if (m_rem[i] == 0 || m_per[i] == 0) return 1'b0;
    return ((m_el[i] / m_per[i]) % 2) == 1;
  endfunction

  function automatic logic m_ready();
    if (int'(cmd_ch) >= NCH) return 1'b1;
    return (m_rem[cmd_ch] == 0) || cmd_force;
  endfunction

  function automatic logic [3*NCH/4*3-0:0] exp_vec_dummy();
    return '0;
  endfunction

  function automatic logic [2*NCH:0] exp_vec();
    logic [NCH-1:0] b;
    for (int i = 0; i < NCH; i++) b[i] = (m_rem[i] != 0);
    return {b, m_done, m_audio};
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int   pc;
    logic any_w;
    logic tk;
    logic acc;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_per[i] <= 0;
        m_rem[i] <= 0;
        m_el[i]  <= 0;
      end
      m_done  <= '0;
      m_audio <= 1'b0;
      m_tcnt  <= 0;
      m_mix   <= 0;
    end else begin
      pc    = 0;
      any_w = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (m_wave(i)) begin
          pc    = pc + 1;
          any_w = 1'b1;
        end
      tk  = (m_tcnt == TICK_DIV - 1);
      acc = cmd_valid && m_ready();
      m_tcnt <= tk ? 0 : m_tcnt + 1;
      for (int i = 0; i < NCH; i++) begin
        if (acc && int'(cmd_ch) == i) begin
          m_per[i]  <= int'(cmd_per);
          m_rem[i]  <= int'(cmd_dur);
          m_el[i]   <= 0;
          m_done[i] <= 1'b0;
        end else if (m_rem[i] != 0) begin
          m_el[i]   <= m_el[i] + 1;
          m_rem[i]  <= tk ? m_rem[i] - 1 : m_rem[i];
          m_done[i] <= tk && (m_rem[i] == 1);
        end else begin
          m_done[i] <= 1'b0;
        end
      end
`ifdef AUDIO_SYNTH_PWM_MIX_EN
      m_audio <= (m_mix < pc);
      m_mix   <= (m_mix + 1) % NCH;
`else
      m_audio <= any_w;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_force = 1'b0;
    cmd_per   = '0;
    cmd_dur   = '0;
  endtask

  task automatic issue(input int ch, input bit frc, input int per, input int dur);
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_force = frc;
    cmd_per   = PSIZE'(per);
    cmd_dur   = DSIZE'(dur);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ch_busy, ch_done, audio_out} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", {ch_busy, ch_done, audio_out}, 9'b0);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_tone();
    int done_cnt = 0;
    int first_rise = -1;
    @(negedge clk);
    issue(0, 0, 3, 5);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL tone_ready: got %b want 1", cmd_ready);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      idle();
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL tone_cyc%0d: got %b want %b", k, {ch_busy, ch_done, audio_out}, exp_vec());
      end
      if (ch_done[0] === 1'b1) done_cnt++;
      if (first_rise < 0 && audio_out === 1'b1) first_rise = k;
    end
    checks++;
    if (first_rise != 5) begin
      errors++;
      $display("FAIL tone_first_rise: got cycle %0d want 5", first_rise);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL tone_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (ch_busy[0] !== 1'b0 || audio_out !== 1'b0) begin
      errors++;
      $display("FAIL tone_end: got busy0=%b audio=%b want 0 0", ch_busy[0], audio_out);
    end
  endtask

  task automatic test_backpressure();
    bit saw_done = 0;
    bit accepted = 0;
    @(negedge clk);
    issue(1, 0, 2, 6);
    @(negedge clk);
    issue(1, 0, 4, 2);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_blocked: got ready=%b want 0", cmd_ready);
    end
    for (int n = 0; n < 80 && !accepted; n++) begin
      @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL bp_cyc%0d: got %b want %b", n, {ch_busy, ch_done, audio_out}, exp_vec());
      end
      if (ch_done[1] === 1'b1) saw_done = 1;
      #1;
      checks++;
      if (cmd_ready !== m_ready()) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b want %b", n, cmd_ready, m_ready());
      end
      if (m_ready()) accepted = 1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL bp_timeout: got no accept want accept within 80 cycles");
    end
    checks++;
    if (!saw_done) begin
      errors++;
      $display("FAIL bp_done_before_ready: got no ch_done[1] want pulse");
    end
    @(negedge clk);
    idle();
    checks++;
    if (ch_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_loaded: got busy1=%b want 1", ch_busy[1]);
    end
    repeat (12) begin
      @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL bp_after: got %b want %b", {ch_busy, ch_done, audio_out}, exp_vec());
      end
    end
  endtask

  task automatic test_force();
    int dn = 0;
    @(negedge clk);
    issue(2, 0, 5, 8);
    repeat (6) begin
      @(negedge clk);
      idle();
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL force_pre: got %b want %b", {ch_busy, ch_done, audio_out}, exp_vec());
      end
    end
    issue(2, 1, 2, 3);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL force_ready: got %b want 1", cmd_ready);
    end
    repeat (20) begin
      @(negedge clk);
      idle();
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL force_cyc: got %b want %b", {ch_busy, ch_done, audio_out}, exp_vec());
      end
      if (ch_done[2] === 1'b1) dn++;
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL force_done_count: got %0d want 1", dn);
    end
  endtask

  task automatic test_coincident();
    int fall = -1;
    int done_k = -1;
    int n = 0;
    @(negedge clk);
    while (m_tcnt != TICK_DIV - 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    issue(3, 0, 1, 2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      idle();
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL coinc_cyc%0d: got %b want %b", k, {ch_busy, ch_done, audio_out}, exp_vec());
      end
      if (fall < 0 && ch_busy[3] === 1'b0) fall = k;
      if (ch_done[3] === 1'b1) done_k = k;
    end
    checks++;
    if (fall != 9 || done_k != 9) begin
      errors++;
      $display("FAIL coinc_expiry: got fall=%0d done=%0d want 9 9", fall, done_k);
    end
  endtask

  task automatic test_mix();
    int hi = 0;
    int hi_exp;
`ifdef AUDIO_SYNTH_PWM_MIX_EN
    hi_exp = 4;
`else
    hi_exp = 8;
`endif
    @(negedge clk);
    issue(0, 0, 20, 15);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL mix_cyc%0d: got %b want %b", k, {ch_busy, ch_done, audio_out}, exp_vec());
      end
      if (k >= 25 && k <= 32 && audio_out === 1'b1) hi++;
      if (k == 1) issue(1, 0, 20, 15);
      else        idle();
    end
    checks++;
    if (hi != hi_exp) begin
      errors++;
      $display("FAIL mix_high_count: got %0d want %0d", hi, hi_exp);
    end
  endtask

  task automatic test_drop_rest();
    @(negedge clk);
    issue(5, 0, 7, 3);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: got %b want 1", cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      idle();
      checks++;
      if (ch_busy !== 4'b0000) begin
        errors++;
        $display("FAIL drop_busy: got %b want 0000", ch_busy);
      end
    end
    issue(2, 0, 0, 2);
    repeat (14) begin
      @(negedge clk);
      idle();
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec() || audio_out !== 1'b0) begin
        errors++;
        $display("FAIL rest_cyc: got %b want %b", {ch_busy, ch_done, audio_out}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, audio_out} !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cyc%0d: got %b want %b", k, {ch_busy, ch_done, audio_out}, exp_vec());
      end
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_ch    = 3'($urandom_range(0, 5));
      cmd_force = ($urandom_range(0, 3) == 0);
      cmd_per   = PSIZE'($urandom_range(0, 6));
      cmd_dur   = DSIZE'($urandom_range(0, 5));
      #1;
      checks++;
      if (cmd_ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready%0d: got %b want %b", k, cmd_ready, m_ready());
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue(0, 1, 3, 9);
    repeat (10) begin
      @(negedge clk);
      idle();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ch_busy, ch_done, audio_out} !== 9'b0) begin
      errors++;
      $display("FAIL midreset_clear: got %b want %b", {ch_busy, ch_done, audio_out}, 9'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, audio_out} !== 9'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_after: got %b ready=%b want 0 ready=1",
                 {ch_busy, ch_done, audio_out}, cmd_ready);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_tone();
    test_backpressure();
    test_force();
    test_coincident();
    test_mix();
    test_drop_rest();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
